// File: rtl/fixed_point_pkg.sv
// Shared fixed-point arithmetic definitions for the multiplier/divider datapath.
// Saturation bounds are functions so each instance can size them from its own W.
package fixed_point_pkg;

  localparam int INTEGER_SIZE_DEF = 16;
  localparam int FRACT_SIZE_DEF   = 16;
  localparam int HALF_LSB         = 1 << (FRACT_SIZE_DEF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RSAT = 2'd2
  } fxp_state_t;

  function automatic logic signed [127:0] max_pos(input int w);
    return (128'sd1 <<< (w - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] max_neg(input int w);
    return -(128'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [127:0] half_lsb(input int f);
    return 128'sd1 <<< (f - 1);
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Round-half-up and saturate a 2W-bit signed Q-format product back to W bits.
// Purely combinational so the divider can share it for quotient scaling.
module fxp_round_sat
  import fixed_point_pkg::*;
#(
  parameter int W = 32,
  parameter int F = 16
) (
  input  logic signed [2*W-1:0] i_product,
  output logic        [W-1:0]   o_result,
  output logic                  o_overflow
);

  localparam int EW = 2 * W + 1;
  localparam logic signed [EW-1:0] HALF  = EW'(half_lsb(F));
  localparam logic signed [EW-1:0] MAX_P = EW'(max_pos(W));
  localparam logic signed [EW-1:0] MAX_N = EW'(max_neg(W));

  logic signed [EW-1:0] w_biased;
  logic signed [EW-1:0] w_rounded;

  // One guard bit keeps the rounding add from wrapping on the largest products.
  assign w_biased  = $signed({i_product[2*W-1], i_product}) + HALF;
  assign w_rounded = w_biased >>> F;

  always_comb begin
    o_result   = w_rounded[W-1:0];
    o_overflow = 1'b0;
    if (w_rounded > MAX_P) begin
      o_result   = MAX_P[W-1:0];
      o_overflow = 1'b1;
    end else if (w_rounded < MAX_N) begin
      o_result   = MAX_N[W-1:0];
      o_overflow = 1'b1;
    end else begin
      o_result   = w_rounded[W-1:0];
      o_overflow = 1'b0;
    end
  end

endmodule

// File: rtl/fixed_point_multiplier.sv
// Signed Q(INTEGER_SIZE).(FRACT_SIZE) radix-2 Booth multiplier, one bit per clock,
// with rounded/saturated registered result and start/end pulse handshake.
module fixed_point_multiplier
  import fixed_point_pkg::*;
#(
  parameter  int INTEGER_SIZE = INTEGER_SIZE_DEF,
  parameter  int FRACT_SIZE   = FRACT_SIZE_DEF,
  localparam int W            = INTEGER_SIZE + FRACT_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_mul,
  input  logic [W-1:0] multiplicand,
  input  logic [W-1:0] multiplier,
  output logic [W-1:0] P_output,
  output logic         end_mul,
  output logic         overflow,
  output logic         busy
);

  localparam int CNT_W = $clog2(W);

  fxp_state_t         r_state;
  logic [W-1:0]       r_a;
  logic [W:0]         r_acc;
  logic [W-1:0]       r_q;
  logic               r_q1;
  logic [CNT_W-1:0]   r_cnt;

  logic [W:0]         w_a_ext;
  logic [W:0]         w_sum;
  logic [2*W-1:0]     w_product;
  logic [W-1:0]       w_result;
  logic               w_overflow;

  assign w_a_ext = {r_a[W-1], r_a};

  // Booth recoding of the current multiplier bit pair into add/sub/skip.
  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_acc + w_a_ext;
      2'b10:   w_sum = r_acc - w_a_ext;
      default: w_sum = r_acc;
    endcase
  end

  // The W+1-bit accumulator only needs its low W bits once all steps are done.
  assign w_product = {r_acc[W-1:0], r_q};

  fxp_round_sat #(
    .W (W),
    .F (FRACT_SIZE)
  ) u_round_sat (
    .i_product  (w_product),
    .o_result   (w_result),
    .o_overflow (w_overflow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_q1     <= 1'b0;
      r_cnt    <= '0;
      P_output <= '0;
      end_mul  <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          end_mul <= 1'b0;
          if (start_mul) begin
            r_a     <= multiplicand;
            r_q     <= multiplier;
            r_acc   <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= {w_sum[W], w_sum[W:1]};
          r_q   <= {w_sum[0], r_q[W-1:1]};
          r_q1  <= r_q[0];
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(W - 1)) begin
            r_state <= RSAT;
          end
        end
        RSAT: begin
          P_output <= w_result;
          overflow <= w_overflow;
          end_mul  <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          end_mul <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Directed bench: Q16.16 behavioural model with per-cycle output checking plus literal pins.
module tb_fixed_point_multiplier;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_mul = 1'b0;
  logic [W-1:0]  multiplicand = '0;
  logic [W-1:0]  multiplier = '0;
  logic [W-1:0]  P_output;
  logic          end_mul;
  logic          overflow;
  logic          busy;

  fixed_point_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .start_mul    (start_mul),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .P_output     (P_output),
    .end_mul      (end_mul),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] p;
    logic        ovf;
  } exp_t;

  exp_t        pend[$];
  int          edge_n = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] held_p = '0;
  logic        held_ovf = 1'b0;
  logic [31:0] last_p = '0;
  logic        last_ovf = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference: exact integer product, round half toward +inf, clamp to 32-bit signed.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] p, output logic ovf);
    longint pa, pb, r;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    r  = (pa * pb + 64'sd32768) >>> 16;
    if (r > 64'sd2147483647) begin
      p = 32'h7FFF_FFFF; ovf = 1'b1;
    end else if (r < -64'sd2147483648) begin
      p = 32'h8000_0000; ovf = 1'b1;
    end else begin
      p = r[31:0]; ovf = 1'b0;
    end
  endfunction

  // Per-cycle compare, 2 time units after each rising edge.
  always @(posedge clk) begin
    logic exp_busy;
    #2;
    if (pend.size() != 0 && edge_n == pend[0].due) begin
      chk("end_mul", {31'd0, end_mul}, 32'd1);
      chk("P_output", P_output, pend[0].p);
      chk("overflow", {31'd0, overflow}, {31'd0, pend[0].ovf});
      chk("busy_at_end", {31'd0, busy}, 32'd0);
      held_p   = pend[0].p;
      held_ovf = pend[0].ovf;
      last_p   = P_output;
      last_ovf = overflow;
      void'(pend.pop_front());
    end else begin
      exp_busy = (pend.size() != 0) && (edge_n < pend[0].due);
      chk("end_mul_idle", {31'd0, end_mul}, 32'd0);
      chk("P_hold", P_output, held_p);
      chk("ovf_hold", {31'd0, overflow}, {31'd0, held_ovf});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    end
  end

  // Pulse start for one cycle; the model accepts it only if no operation is pending.
  task automatic issue_start(input logic [31:0] a, input logic [31:0] b, output int e0);
    exp_t x;
    @(negedge clk);
    e0 = edge_n + 1;
    start_mul = 1'b1;
    multiplicand = a;
    multiplier = b;
    if (pend.size() == 0 || e0 > pend[pend.size()-1].due) begin
      x.due = e0 + LAT;
      model(a, b, x.p, x.ovf);
      pend.push_back(x);
    end
    @(negedge clk);
    start_mul = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (pend.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (pend.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: no end_mul within %0d cycles, pending %0d", n, pend.size());
      pend.delete();
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p, input logic exp_ovf);
    int e0;
    issue_start(a, b, e0);
    wait_done();
    chk({name, "_p"}, last_p, exp_p);
    chk({name, "_ovf"}, {31'd0, last_ovf}, {31'd0, exp_ovf});
  endtask

  initial begin
    int e0;
    int n;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_P", P_output, 32'h0);
    chk("reset_end", {31'd0, end_mul}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;

    run_op("basic", 32'h0002_8000, 32'hFFFF_0000, 32'hFFFD_8000, 1'b0);
    run_op("frac", 32'h0001_8000, 32'h0001_8000, 32'h0002_4000, 1'b0);
    run_op("round_up", 32'h0000_0001, 32'h0000_8000, 32'h0000_0001, 1'b0);
    run_op("round_neg", 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 1'b0);
    run_op("sat_pos", 32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1);
    run_op("sat_minsq", 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    run_op("sat_neg", 32'h8000_0000, 32'h0002_0000, 32'h8000_0000, 1'b1);
    run_op("ovf_clear", 32'h0001_8000, 32'h0001_8000, 32'h0002_4000, 1'b0);
    run_op("zero", 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0);

    // start while busy, sampled at edge 5 of the running operation
    issue_start(32'h0002_8000, 32'hFFFF_0000, e0);
    while (edge_n < e0 + 4) @(negedge clk);
    issue_start(32'h0001_8000, 32'h0001_8000, n);
    wait_done();
    chk("busy_ignore_p", last_p, 32'hFFFD_8000);

    // back-to-back: second start lands in the end_mul cycle
    issue_start(32'h0001_8000, 32'h0001_8000, e0);
    n = 0;
    while (end_mul !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_p", P_output, 32'h0002_4000);
    start_mul = 1'b1;
    multiplicand = 32'h0002_8000;
    multiplier = 32'hFFFF_0000;
    begin
      exp_t x;
      x.due = edge_n + 1 + LAT;
      model(32'h0002_8000, 32'hFFFF_0000, x.p, x.ovf);
      pend.push_back(x);
    end
    @(negedge clk);
    start_mul = 1'b0;
    wait_done();
    chk("b2b_second_p", last_p, 32'hFFFD_8000);

    // operands toggle after being sampled
    issue_start(32'h0001_8000, 32'h0001_8000, e0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      multiplicand = $urandom;
      multiplier = $urandom;
    end
    wait_done();
    chk("toggle_p", last_p, 32'h0002_4000);

    // asynchronous reset mid-operation
    issue_start(32'h0002_8000, 32'hFFFF_0000, e0);
    while (edge_n < e0 + 10) @(posedge clk);
    #1;
    rst = 1'b0;
    pend.delete();
    held_p = '0;
    held_ovf = 1'b0;
    #1;
    chk("midrst_P", P_output, 32'h0);
    chk("midrst_end", {31'd0, end_mul}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    run_op("after_rst", 32'h0002_8000, 32'hFFFF_0000, 32'hFFFD_8000, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
